// File: rtl/bin2bcd_converter_pkg.sv
// Shared constants for the binary-to-BCD converter: default widths, state
// encoding and the display range limits used by the benches.
package bin2bcd_converter_pkg;

  localparam int DEF_IN_WIDTH       = 16;
  localparam int DEF_BCD_DIGITS     = 5;
  localparam int OUT_DIGITS         = 4;
  localparam int OVERFLOW_THRESHOLD = 9999;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding the 4-digit display; bcd/overflow only change on completion.
module bin2bcd_converter
  import bin2bcd_converter_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int BCD_DIGITS = DEF_BCD_DIGITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     bin,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_DIGITS*4-1:0] bcd,
  output logic                    overflow
);

  localparam int ACC_W = BCD_DIGITS * 4;
  localparam int OUT_W = OUT_DIGITS * 4;
  localparam int CNT_W = $clog2(IN_WIDTH) + 1;

  state_t              state;
  logic [IN_WIDTH-1:0] bin_sr;
  logic [IN_WIDTH-1:0] next_sr;
  logic [ACC_W-1:0]    bcd_acc;
  logic [ACC_W-1:0]    acc_adj;
  logic [ACC_W-1:0]    next_acc;
  logic [CNT_W-1:0]    count;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adjust
    bcd_digit_adjust u_adjust (
      .digit   (bcd_acc[d*4 +: 4]),
      .adjusted(acc_adj[d*4 +: 4])
    );
  end

  // Adjusted accumulator and binary shift register move left as one word.
  assign next_acc = ACC_W'({acc_adj, bin_sr[IN_WIDTH-1]});
  assign next_sr  = IN_WIDTH'({bin_sr, 1'b0});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      bin_sr   <= '0;
      bcd_acc  <= '0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            bcd_acc <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bcd_acc <= next_acc;
          bin_sr  <= next_sr;
          count   <= count + 1'b1;
          // Last iteration publishes the result straight from the shift path.
          if (count == CNT_W'(IN_WIDTH - 1)) begin
            bcd      <= next_acc[OUT_W-1:0];
            overflow <= |next_acc[ACC_W-1:OUT_W];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Self-checking bench for bin2bcd_converter: decimal reference model built
// from plain integer arithmetic, scenario tasks plus randomized values.
module tb_bin2bcd_converter;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  int tests;
  int fails;

  bin2bcd_converter dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: low four decimal digits of the value, packed one per nibble.
  function automatic logic [15:0] ref_bcd(input int value);
    int m;
    m = value % 10000;
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic ref_ovf(input int value);
    return (value > 9999);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts one conversion and follows it to done (bounded), reporting what was seen.
  task automatic run_conversion(input logic [15:0] value, output bit done_seen,
                                output int busy_cycles, output int latency,
                                output logic [15:0] bcd_seen, output logic ovf_seen,
                                output bit held);
    logic [15:0] prev_bcd;
    logic        prev_ovf;
    prev_bcd    = bcd;
    prev_ovf    = overflow;
    done_seen   = 1'b0;
    busy_cycles = 0;
    latency     = 0;
    bcd_seen    = 16'h0000;
    ovf_seen    = 1'b0;
    held        = 1'b1;
    bin   = value;
    start = 1'b1;
    step();
    start = 1'b0;
    bin   = 16'($urandom);
    for (int n = 1; n <= 40 && !done_seen; n++) begin
      if (busy) busy_cycles++;
      if (bcd !== prev_bcd || overflow !== prev_ovf) held = 1'b0;
      step();
      if (done) begin
        done_seen = 1'b1;
        latency   = n;
        bcd_seen  = bcd;
        ovf_seen  = overflow;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    bin   = 16'h0000;
    step();
    step();
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests++; if (bcd !== 16'h0000) begin fails++; $display("[TB] FAIL reset_bcd got %h want 0000", bcd); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf got %b want 0", overflow); end
    #3 reset = 1'b1;
    step();
  endtask

  task automatic test_zero();
    bit ds, held; int bc, lat; logic [15:0] b; logic o;
    run_conversion(16'd0, ds, bc, lat, b, o, held);
    tests++; if (!ds || lat != 16) begin fails++; $display("[TB] FAIL zero_latency got done=%0b lat=%0d want 16", ds, lat); end
    tests++; if (bc != 16) begin fails++; $display("[TB] FAIL zero_busy_cycles got %0d want 16", bc); end
    tests++; if (b !== 16'h0000 || o !== 1'b0) begin fails++; $display("[TB] FAIL zero_result got %h/%b want 0000/0", b, o); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL zero_busy_at_done got %b want 0", busy); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL zero_done_pulse got %b want 0", done); end
  endtask

  // Directed values around the display range, then random ones.
  task automatic test_values();
    int vals[6] = '{1234, 9999, 10000, 65535, 9990, 1};
    bit ds, held; int bc, lat; logic [15:0] b; logic o;
    int v;
    for (int i = 0; i < 26; i++) begin
      v = (i < 6) ? vals[i] : int'($urandom_range(0, 65535));
      run_conversion(16'(v), ds, bc, lat, b, o, held);
      tests++;
      if (!ds || lat != 16 || b !== ref_bcd(v) || o !== ref_ovf(v)) begin
        fails++;
        $display("[TB] FAIL value_%0d got done=%0b lat=%0d bcd=%h ovf=%b want lat=16 bcd=%h ovf=%b",
                 v, ds, lat, b, o, ref_bcd(v), ref_ovf(v));
      end
    end
  endtask

  task automatic test_back_to_back();
    int early_done;
    int lat;
    early_done = 0;
    bin   = 16'd42;
    start = 1'b1;
    step();
    for (int n = 1; n <= 16; n++) begin
      if (n == 5) begin start = 1'b1; bin = 16'd7777; end
      else start = 1'b0;
      step();
      if (n < 16 && done) early_done++;
    end
    tests++; if (early_done != 0) begin fails++; $display("[TB] FAIL ignore_early_done got %0d want 0", early_done); end
    tests++; if (done !== 1'b1 || bcd !== 16'h0042 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL ignore_result got done=%b bcd=%h ovf=%b want 1/0042/0", done, bcd, overflow); end
    start = 1'b1;
    bin   = 16'd7;
    step();
    start = 1'b0;
    bin   = 16'd9000;
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("[TB] FAIL b2b_accept got busy=%b done=%b want 1/0", busy, done); end
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      step();
      if (done) lat = n;
    end
    tests++; if (lat != 16 || bcd !== 16'h0007 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL b2b_result got lat=%0d bcd=%h ovf=%b want 16/0007/0", lat, bcd, overflow); end
    step();
  endtask

  task automatic test_hold();
    bit ds, held; int bc, lat; logic [15:0] b; logic o;
    run_conversion(16'd5678, ds, bc, lat, b, o, held);
    tests++; if (!ds || b !== 16'h5678) begin fails++; $display("[TB] FAIL hold_first got %h want 5678", b); end
    run_conversion(16'd1111, ds, bc, lat, b, o, held);
    tests++; if (!held) begin fails++; $display("[TB] FAIL hold_stable got changed want held at 5678"); end
    tests++; if (!ds || lat != 16 || b !== 16'h1111) begin fails++; $display("[TB] FAIL hold_second got lat=%0d bcd=%h want 16/1111", lat, b); end
  endtask

  task automatic test_reset_mid();
    int spurious;
    bin   = 16'd4321;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 7; n++) step();
    #2 reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("[TB] FAIL midreset_ctrl got busy=%b done=%b want 0/0", busy, done); end
    tests++; if (bcd !== 16'h0000 || overflow !== 1'b0) begin fails++; $display("[TB] FAIL midreset_data got %h/%b want 0000/0", bcd, overflow); end
    step();
    #2 reset = 1'b1;
    spurious = 0;
    for (int n = 0; n < 24; n++) begin
      step();
      if (done || busy) spurious++;
    end
    tests++; if (spurious != 0) begin fails++; $display("[TB] FAIL midreset_quiet got %0d active cycles want 0", spurious); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    start = 1'b0;
    bin   = 16'h0000;
    reset = 1'b0;
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
